// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// Module      : irq_ctrl_if
// Description : chip_select-qualified data-bus slave port for irq_ctrl.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface irq_ctrl_if;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic        wb_dbus_we;
  logic        cyc;
  logic [31:0] rdt;

  modport master (output wb_dbus_adr, wb_dbus_dat, wb_dbus_we, cyc, input rdt);
  modport slave  (input wb_dbus_adr, wb_dbus_dat, wb_dbus_we, cyc, output rdt);
endinterface

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// Module      : irq_ctrl
// Description : Interrupt aggregator: source sync, edge latch, enable mask,
//               registered irq output and bus-visible status/ID registers.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module irq_ctrl #(
  parameter int           N           = 8,
  parameter int           SYNC_STAGES = 2,
  parameter logic [N-1:0] SYNC_MASK   = {N{1'b1}},
  parameter logic [N-1:0] EDGE_MASK   = {N{1'b0}}
) (
  input  wire logic         wb_clk,
  input  wire logic         wb_rst_n,
  input  wire logic [N-1:0] irq_src,
  irq_ctrl_if.slave         bus,
  output logic              irq
);

  localparam logic [2:0] c_ADR_STATUS  = 3'd0;
  localparam logic [2:0] c_ADR_PENDING = 3'd1;
  localparam logic [2:0] c_ADR_ENABLE  = 3'd2;
  localparam logic [2:0] c_ADR_ACTIVE  = 3'd3;
  localparam logic [2:0] c_ADR_ID      = 3'd5;

  logic [N-1:0] w_s;
  logic [N-1:0] r_prev;
  logic [N-1:0] r_pend;
  logic [N-1:0] r_enable;
  logic         r_irq;
  logic [N-1:0] w_event;
  logic [N-1:0] w_set;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pending;
  logic [N-1:0] w_active;
  logic [N-1:0] w_wdat;
  logic [2:0]   w_adr;
  logic         w_wr;
  logic         w_rd;
  logic [4:0]   w_idx;
  logic [31:0]  w_rdata;
  logic         w_unused_bits;

  for (genvar i = 0; i < N; i++) begin : g_src
    if (SYNC_MASK[i]) begin : g_sync
      logic [SYNC_STAGES-1:0] r_chain;
      always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) r_chain <= '0;
        else           r_chain <= {r_chain[SYNC_STAGES-2:0], irq_src[i]};
      end
      assign w_s[i] = r_chain[SYNC_STAGES-1];
    end else begin : g_bypass
      assign w_s[i] = irq_src[i];
    end
  end

  assign w_adr  = bus.wb_dbus_adr[4:2];
  assign w_wdat = bus.wb_dbus_dat[N-1:0];
  assign w_wr   = bus.cyc & bus.wb_dbus_we;
  assign w_rd   = bus.cyc & ~bus.wb_dbus_we;

  assign w_unused_bits = ^{bus.wb_dbus_adr[31:5], bus.wb_dbus_adr[1:0], bus.wb_dbus_dat};

  // Only edge-configured bits carry latched state; level bits mirror s.
  assign w_event   = w_s & ~r_prev & EDGE_MASK;
  assign w_set     = (w_wr && w_adr == 3'd4)          ? (w_wdat & EDGE_MASK) : '0;
  assign w_clr     = (w_wr && w_adr == c_ADR_PENDING) ? (w_wdat & EDGE_MASK) : '0;
  assign w_pending = (r_pend & EDGE_MASK) | (w_s & ~EDGE_MASK);
  assign w_active  = w_pending & r_enable;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_prev   <= '0;
      r_pend   <= '0;
      r_enable <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev <= w_s;
      // Set and new events take priority over a simultaneous clear.
      r_pend <= ((r_pend & ~w_clr) | w_event | w_set) & EDGE_MASK;
      if (w_wr && w_adr == c_ADR_ENABLE) r_enable <= w_wdat;
      r_irq  <= |w_active;
    end
  end

  assign irq = r_irq;

  always_comb begin
    w_idx = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_active[i]) w_idx = 5'(i);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      c_ADR_STATUS:  w_rdata[N-1:0] = w_s;
      c_ADR_PENDING: w_rdata[N-1:0] = w_pending;
      c_ADR_ENABLE:  w_rdata[N-1:0] = r_enable;
      c_ADR_ACTIVE:  w_rdata[N-1:0] = w_active;
      c_ADR_ID: begin
        w_rdata[31]  = |w_active;
        w_rdata[4:0] = w_idx;
      end
      default:       w_rdata = '0;
    endcase
  end

  assign bus.rdt = w_rd ? w_rdata : 32'd0;

endmodule

`default_nettype wire
